dvp_sensor_gen: RTL



---
 rtl/dvp_gen_pkg.sv | 23 ++
 rtl/dvp_colorbar_lut.sv | 23 ++
 rtl/dvp_sensor_gen.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/dvp_gen_pkg.sv
// Shared constants for the DVP sensor emulator: pattern modes, FSM states, colour-bar palette.
package dvp_gen_pkg;

    localparam logic [1:0] MODE_CNT   = 2'd0;
    localparam logic [1:0] MODE_BARS  = 2'd1;
    localparam logic [1:0] MODE_SOLID = 2'd2;

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_RUN  = 2'd1;
    localparam state_t ST_STOP = 2'd2;

    // RGB565 bars, left to right
    localparam logic [15:0] BAR_WHITE   = 16'hFFFF;
    localparam logic [15:0] BAR_YELLOW  = 16'hFFE0;
    localparam logic [15:0] BAR_CYAN    = 16'h07FF;
    localparam logic [15:0] BAR_GREEN   = 16'h07E0;
    localparam logic [15:0] BAR_MAGENTA = 16'hF81F;
    localparam logic [15:0] BAR_RED     = 16'hF800;
    localparam logic [15:0] BAR_BLUE    = 16'h001F;
    localparam logic [15:0] BAR_BLACK   = 16'h0000;

endpackage

// File: rtl/dvp_colorbar_lut.sv
// Bar index to RGB565 colour; purely combinational.
module dvp_colorbar_lut
    import dvp_gen_pkg::*;
(
    input  logic [2:0]  bar,
    output logic [15:0] rgb
);

    always_comb begin
        rgb = BAR_BLACK;
        case (bar)
            3'd0:    rgb = BAR_WHITE;
            3'd1:    rgb = BAR_YELLOW;
            3'd2:    rgb = BAR_CYAN;
            3'd3:    rgb = BAR_GREEN;
            3'd4:    rgb = BAR_MAGENTA;
            3'd5:    rgb = BAR_RED;
            3'd6:    rgb = BAR_BLUE;
            default: rgb = BAR_BLACK;
        endcase
    end

endmodule

// File: rtl/dvp_sensor_gen.sv
// OV5640-style DVP sensor emulator: vsync/href/byte-serial pixels with test patterns.
// Define DVP_SENSOR_GEN_COLORBAR_EN to enable the colour-bar pattern (mode 1).
module dvp_sensor_gen
    import dvp_gen_pkg::*;
#(
    parameter int   DATA_W        = 8,
    parameter int   BYTES_PER_PIX = 2,
    parameter int   H_VALID       = 640,
    parameter int   H_TOTAL       = 784,
    parameter int   V_SYNC        = 4,
    parameter int   V_BACK        = 18,
    parameter int   V_VALID       = 480,
    parameter int   V_TOTAL       = 510,
    parameter logic VSYNC_POL     = 1'b1
)
(
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic              enable,
    input  logic [1:0]        mode,
    input  logic [15:0]       solid_rgb,
    output logic              dvp_vsync,
    output logic              dvp_href,
    output logic [DATA_W-1:0] dvp_data,
    output logic              frame_start,
    output logic [15:0]       frame_cnt,
    output logic              busy
);

    localparam int LINE_B = H_TOTAL * BYTES_PER_PIX;
    // One spare bit so limits equal to the total never wrap to zero
    localparam int HW = $clog2(LINE_B + 1);
    localparam int VW = $clog2(V_TOTAL + 1);

    localparam logic [HW-1:0] H_MAX     = HW'(LINE_B - 1);
    localparam logic [HW-1:0] H_ACT     = HW'(H_VALID * BYTES_PER_PIX);
    localparam logic [VW-1:0] V_MAX     = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_SYNC_E  = VW'(V_SYNC);
    localparam logic [VW-1:0] V_ACT_B   = VW'(V_SYNC + V_BACK);
    localparam logic [VW-1:0] V_ACT_E   = VW'(V_SYNC + V_BACK + V_VALID);

    state_t            state, state_nxt;
    logic [HW-1:0]     cnt_h;
    logic [VW-1:0]     cnt_v;
    logic              run, frame_end, frame_top;
    logic              vsync_act, href_act;
    logic [1:0]        mode_q;
    logic [15:0]       rgb_q;
    logic [DATA_W-1:0] byte_cnt;
    logic [15:0]       pix_rgb;
    logic [7:0]        pix_byte;
    logic              lo_byte, use_rgb;
    logic [DATA_W-1:0] pat;

    assign run       = (state != ST_IDLE);
    assign busy      = run;
    assign frame_end = (cnt_v == V_MAX) && (cnt_h == H_MAX);
    assign frame_top = (cnt_v == '0) && (cnt_h == '0);
    assign vsync_act = run && (cnt_v < V_SYNC_E);
    assign href_act  = run && (cnt_h < H_ACT) && (cnt_v >= V_ACT_B) && (cnt_v < V_ACT_E);

    // Dropping enable exactly on the last byte ends the frame without a STOP detour
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (enable) state_nxt = ST_RUN;
            ST_RUN:  if (!enable) state_nxt = frame_end ? ST_IDLE : ST_STOP;
            ST_STOP: begin
                if (enable)         state_nxt = ST_RUN;
                else if (frame_end) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) state <= ST_IDLE;
        else            state <= state_nxt;
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cnt_h <= '0;
            cnt_v <= '0;
        end else if (!run) begin
            cnt_h <= '0;
            cnt_v <= '0;
        end else if (cnt_h == H_MAX) begin
            cnt_h <= '0;
            cnt_v <= (cnt_v == V_MAX) ? '0 : cnt_v + 1'b1;
        end else begin
            cnt_h <= cnt_h + 1'b1;
        end
    end

    // Pattern settings only change on a frame boundary
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            mode_q <= MODE_CNT;
            rgb_q  <= '0;
        end else if (frame_top) begin
            mode_q <= mode;
            rgb_q  <= solid_rgb;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n)    byte_cnt <= '0;
        else if (href_act) byte_cnt <= byte_cnt + 1'b1;
        else               byte_cnt <= '0;
    end

    assign lo_byte = (BYTES_PER_PIX == 2) ? cnt_h[0] : 1'b0;

`ifdef DVP_SENSOR_GEN_COLORBAR_EN
    logic [HW-1:0] pixel_x;
    logic [2:0]    bar;
    logic [15:0]   bar_rgb;

    // H_VALID is a multiple of 8, so inside href the bar index stays in 0..7
    assign pixel_x = cnt_h / HW'(BYTES_PER_PIX);
    assign bar     = 3'(pixel_x / HW'(H_VALID / 8));

    dvp_colorbar_lut u_lut (
        .bar (bar),
        .rgb (bar_rgb)
    );

    assign pix_rgb = (mode_q == MODE_BARS) ? bar_rgb : rgb_q;
    assign use_rgb = (mode_q == MODE_BARS) || (mode_q == MODE_SOLID);
`else
    assign pix_rgb = rgb_q;
    assign use_rgb = (mode_q == MODE_SOLID);
`endif

    assign pix_byte = lo_byte ? pix_rgb[7:0] : pix_rgb[15:8];
    assign pat      = use_rgb ? DATA_W'(pix_byte) : byte_cnt;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            dvp_vsync   <= ~VSYNC_POL;
            dvp_href    <= 1'b0;
            dvp_data    <= '0;
            frame_start <= 1'b0;
            frame_cnt   <= '0;
        end else begin
            dvp_vsync   <= vsync_act ? VSYNC_POL : ~VSYNC_POL;
            dvp_href    <= href_act;
            dvp_data    <= href_act ? pat : '0;
            frame_start <= run && frame_top;
            if (run && frame_top) frame_cnt <= frame_cnt + 1'b1;
        end
    end

endmodule
